// File: rtl/rowwise_arbiter.sv
// Round-robin arbiter and sequencer sharing one rowwise_operation unit among NUM_REQ requesters.
// One vector job (a, b, op) is accepted at a time, issued to the unit over a valid/ready
// handshake, run for D cycles while the accumulator captures new_result, and returned with the
// owning requester id over a valid/ready response port.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   req_valid_i / req_ready_o     per-requester job handshake (ready is one-hot or zero)
//   req_a_i, req_b_i, req_op_i    per-requester operands and operation
//   rsp_valid_o / rsp_ready_i     result handshake
//   rsp_result_o, rsp_id_o        finished vector and owning requester id
//   fu_a_o, fu_b_o, fu_op_o       operands held stable for the unit
//   fu_valid_o / fu_ready_i       unit in_valid / in_ready
//   fu_new_result_i               unit new_result, captured every RUN cycle
//   fu_old_result_o               accumulator fed back to the unit's old_result
//   busy_o                        high whenever a job is in flight
module rowwise_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ),
  parameter int unsigned D       = 4,   // vector length, must match the unit
  parameter int unsigned ELEM_W  = 16,  // element width of vector_t
  parameter int unsigned OP_W    = 2    // width of operation_t
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic [NUM_REQ-1:0]                         req_valid_i,
  output logic [NUM_REQ-1:0]                         req_ready_o,
  input  logic [NUM_REQ-1:0][D-1:0][ELEM_W-1:0]      req_a_i,
  input  logic [NUM_REQ-1:0][D-1:0][ELEM_W-1:0]      req_b_i,
  input  logic [NUM_REQ-1:0][OP_W-1:0]               req_op_i,
  output logic                                       rsp_valid_o,
  input  logic                                       rsp_ready_i,
  output logic [D-1:0][ELEM_W-1:0]                   rsp_result_o,
  output logic [ID_W-1:0]                            rsp_id_o,
  output logic [D-1:0][ELEM_W-1:0]                   fu_a_o,
  output logic [D-1:0][ELEM_W-1:0]                   fu_b_o,
  output logic [OP_W-1:0]                            fu_op_o,
  output logic                                       fu_valid_o,
  input  logic                                       fu_ready_i,
  input  logic [D-1:0][ELEM_W-1:0]                   fu_new_result_i,
  output logic [D-1:0][ELEM_W-1:0]                   fu_old_result_o,
  output logic                                       busy_o
);

  localparam int unsigned CntW = (D > 1) ? $clog2(D) : 1;

  typedef logic [D-1:0][ELEM_W-1:0] vector_t;
  typedef logic [OP_W-1:0]          operation_t;

  typedef enum logic [1:0] {StIdle, StIssue, StRun, StResp} state_e;

  state_e           state_q;
  logic [ID_W-1:0]  rr_ptr_q;
  logic [CntW-1:0]  count_q;
  vector_t          a_q, b_q, result_q;
  operation_t       op_q;
  logic [ID_W-1:0]  id_q;
  logic             fu_valid_q, rsp_valid_q, busy_q;

  // Round-robin pick: first valid requester scanning upward from rr_ptr_q.
  logic            gnt_valid;
  logic [ID_W-1:0] gnt_idx;
  logic [ID_W-1:0] cand_idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_idx = ID_W'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!gnt_valid && req_valid_i[cand_idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand_idx;
      end
    end
  end

  // Accept is combinational so a waiting requester is taken in the first IDLE cycle.
  always_comb begin
    req_ready_o = '0;
    if (!rst_i && (state_q == StIdle) && gnt_valid) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  logic [ID_W-1:0] rr_next;
  assign rr_next = (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      count_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      id_q        <= '0;
      result_q    <= '0;
      fu_valid_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            a_q        <= req_a_i[gnt_idx];
            b_q        <= req_b_i[gnt_idx];
            op_q       <= req_op_i[gnt_idx];
            id_q       <= gnt_idx;
            result_q   <= '0;
            fu_valid_q <= 1'b1;
            busy_q     <= 1'b1;
            state_q    <= StIssue;
          end
        end
        StIssue: begin
          if (fu_ready_i) begin
            count_q    <= '0;
            fu_valid_q <= 1'b0;
            state_q    <= StRun;
          end
        end
        StRun: begin
          result_q <= fu_new_result_i;
          count_q  <= count_q + 1'b1;
          if (count_q == CntW'(D - 1)) begin
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            rr_ptr_q    <= rr_next;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign fu_a_o          = a_q;
  assign fu_b_o          = b_q;
  assign fu_op_o         = op_q;
  assign fu_old_result_o = result_q;
  assign rsp_result_o    = result_q;
  assign rsp_id_o        = id_q;
  assign fu_valid_o      = fu_valid_q;
  assign rsp_valid_o     = rsp_valid_q;
  assign busy_o          = busy_q;

endmodule
